// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - N-channel key debouncer with press/release pulses; optional long press via KEY_LONG_PRESS_EN
module key_debounce_multi #(
    parameter int                KEY_NUM      = 4,
    parameter int                CNT_W        = 20,
    parameter logic [CNT_W-1:0]  DEBOUNCE_CNT = 20'd1_000_000,
    parameter logic              PRESS_LEVEL  = 1'b0,
    parameter int                LONG_W       = 26,
    parameter logic [LONG_W-1:0] LONG_CNT     = 26'd50_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_filter,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    localparam logic IDLE_LEVEL = ~PRESS_LEVEL;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        logic             key_d0_q;
        logic             key_d1_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             filter_q;
        logic             press_q;
        logic             release_q;
        logic             commit;

        // Any difference across the synchroniser means the pin moved: restart the stability window.
        always_comb begin
            cnt_d = cnt_q;
            if (key_d0_q != key_d1_q) begin
                cnt_d = DEBOUNCE_CNT;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        assign commit = (cnt_q == CNT_W'(1));

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                key_d0_q  <= IDLE_LEVEL;
                key_d1_q  <= IDLE_LEVEL;
                cnt_q     <= '0;
                filter_q  <= IDLE_LEVEL;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                key_d0_q  <= key[i];
                key_d1_q  <= key_d0_q;
                cnt_q     <= cnt_d;
                press_q   <= commit && (key_d1_q != filter_q) && (key_d1_q == PRESS_LEVEL);
                release_q <= commit && (key_d1_q != filter_q) && (key_d1_q != PRESS_LEVEL);
                if (commit) begin
                    filter_q <= key_d1_q;
                end
            end
        end

        assign key_filter[i]  = filter_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;

`ifdef KEY_LONG_PRESS_EN
        logic [LONG_W-1:0] hold_q;
        logic              long_q;

        // Hold counter saturates at LONG_CNT so the long event fires once per press.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else if (filter_q != PRESS_LEVEL) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else if (hold_q != LONG_CNT) begin
                hold_q <= hold_q + LONG_W'(1);
                long_q <= (hold_q == LONG_CNT - LONG_W'(1));
            end else begin
                long_q <= 1'b0;
            end
        end

        assign key_long[i] = long_q;
`else
        assign key_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - self-checking bench for key_debounce_multi against a run-length reference model
module tb_key_debounce_multi;

    localparam int   KN = 4;
    localparam int   D  = 8;
    localparam int   LC = 20;
    localparam logic PL = 1'b0;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [KN-1:0] key = '0;
    logic [KN-1:0] key_filter, key_press, key_release, key_long;

    key_debounce_multi #(
        .KEY_NUM(KN), .CNT_W(4), .DEBOUNCE_CNT(4'd8), .PRESS_LEVEL(1'b0),
        .LONG_W(26), .LONG_CNT(26'd20)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key),
        .key_filter(key_filter), .key_press(key_press),
        .key_release(key_release), .key_long(key_long)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    logic [KN-1:0] m_s1, m_s2, m_yprev, m_filt;
    int            m_run[KN];
    int            m_hold[KN];
    logic [KN-1:0] exp_filt, exp_press, exp_rel, exp_long;

    int press_cnt[KN], press_edge[KN], rel_cnt[KN], rel_edge[KN], long_cnt[KN], long_edge[KN];

    task automatic check(input string tag, input logic [KN-1:0] obs, input logic [KN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Filter follows the twice-delayed pin once that value has been seen unchanged for exactly D edges.
    task automatic model_edge(input logic [KN-1:0] kv, input logic rv);
        logic y;
        exp_press = '0;
        exp_rel   = '0;
        exp_long  = '0;
        for (int ch = 0; ch < KN; ch++) begin
            if (!rv) begin
                m_s1[ch]    = ~PL;
                m_s2[ch]    = ~PL;
                m_yprev[ch] = ~PL;
                m_run[ch]   = 1000000;
                m_filt[ch]  = ~PL;
                m_hold[ch]  = 0;
            end else begin
                y = m_s2[ch];
                if (y == m_yprev[ch]) begin
                    if (m_run[ch] < 1000000) m_run[ch]++;
                end else begin
                    m_run[ch] = 1;
                end
                m_yprev[ch] = y;
                m_s2[ch]    = m_s1[ch];
                m_s1[ch]    = kv[ch];
                if (m_filt[ch] != PL) begin
                    m_hold[ch] = 0;
                end else if (m_hold[ch] < LC) begin
                    m_hold[ch]++;
                    exp_long[ch] = (m_hold[ch] == LC);
                end
                if (m_run[ch] == D) begin
                    exp_press[ch] = (y != m_filt[ch]) && (y == PL);
                    exp_rel[ch]   = (y != m_filt[ch]) && (y != PL);
                    m_filt[ch]    = y;
                end
            end
        end
`ifndef KEY_LONG_PRESS_EN
        exp_long = '0;
`endif
        exp_filt = m_filt;
    endtask

    task automatic clear_stats();
        for (int ch = 0; ch < KN; ch++) begin
            press_cnt[ch] = 0; press_edge[ch] = -1;
            rel_cnt[ch]   = 0; rel_edge[ch]   = -1;
            long_cnt[ch]  = 0; long_edge[ch]  = -1;
        end
    endtask

    task automatic step();
        logic [KN-1:0] kv;
        logic          rv;
        kv = key;
        rv = sys_rst_n;
        @(posedge sys_clk);
        model_edge(kv, rv);
        edge_no++;
        #1;
        check("filter", key_filter, exp_filt);
        check("press", key_press, exp_press);
        check("release", key_release, exp_rel);
        check("long", key_long, exp_long);
        for (int ch = 0; ch < KN; ch++) begin
            if (key_press[ch])   begin press_cnt[ch]++; press_edge[ch] = edge_no; end
            if (key_release[ch]) begin rel_cnt[ch]++;   rel_edge[ch]   = edge_no; end
            if (key_long[ch])    begin long_cnt[ch]++;  long_edge[ch]  = edge_no; end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int sim_hit;
        int p_edge;

        key = 4'h0;
        sys_rst_n = 1'b0;
        repeat (3) step();
        check("reset_filter", key_filter, 4'hF);
        check("reset_pulses", key_press | key_release | key_long, 4'h0);

        // Keys held pressed through reset release.
        clear_stats();
        base = edge_no;
        sys_rst_n = 1'b1;
        repeat (15) step();
        for (int ch = 0; ch < KN; ch++) begin
            check_int("rst_press_edge", press_edge[ch] - base, D + 2);
            check_int("rst_press_count", press_cnt[ch], 1);
        end

        key = 4'hF;
        repeat (15) step();

        // Clean press and release.
        clear_stats();
        base = edge_no;
        key[0] = 1'b0;
        repeat (14) step();
        check_int("clean_press_edge", press_edge[0] - base, D + 2);
        check_int("clean_press_count", press_cnt[0], 1);
        base = edge_no;
        key[0] = 1'b1;
        repeat (14) step();
        check_int("clean_release_edge", rel_edge[0] - base, D + 2);
        check_int("clean_release_count", rel_cnt[0], 1);

        // Bounce: five toggles every 3 cycles, ending low.
        clear_stats();
        base = edge_no;
        for (int t = 0; t < 5; t++) begin
            key[1] = ~key[1];
            base = edge_no;
            repeat (3) step();
            check_int("bounce_quiet", press_cnt[1] + rel_cnt[1], 0);
        end
        repeat (14) step();
        check_int("bounce_press_count", press_cnt[1], 1);
        check_int("bounce_press_edge", press_edge[1] - base, D + 2);
        check_int("bounce_release_count", rel_cnt[1], 0);
        key[1] = 1'b1;
        repeat (14) step();

        // Glitch shorter than the debounce window.
        clear_stats();
        key[2] = 1'b0;
        repeat (4) step();
        key[2] = 1'b1;
        repeat (16) step();
        check_int("glitch_events", press_cnt[2] + rel_cnt[2], 0);
        check("glitch_filter", key_filter, 4'hF);

        // Simultaneous press on channels 3 and 0.
        clear_stats();
        sim_hit = 0;
        key[3] = 1'b0;
        key[0] = 1'b0;
        repeat (14) begin
            step();
            if (key_press == 4'b1001) sim_hit++;
        end
        check_int("simul_press", sim_hit, 1);
        key = 4'hF;
        repeat (14) step();

        // Long hold.
        clear_stats();
        key[0] = 1'b0;
        repeat (40) step();
`ifdef KEY_LONG_PRESS_EN
        check_int("long_count", long_cnt[0], 1);
        check_int("long_edge", long_edge[0] - press_edge[0], LC);
`else
        check_int("long_count", long_cnt[0], 0);
`endif
        key[0] = 1'b1;
        repeat (14) step();

        // Filter released 15 cycles after the press: no long event.
        clear_stats();
        key[0] = 1'b0;
        repeat (D + 2) step();
        p_edge = press_edge[0];
        check_int("short_press_edge_seen", press_cnt[0], 1);
        repeat (5) step();
        key[0] = 1'b1;
        repeat (20) step();
        check_int("short_release_gap", rel_edge[0] - p_edge, 15);
        check_int("short_no_long", long_cnt[0], 0);

        // Reset in the middle of a count.
        clear_stats();
        key[3] = 1'b0;
        repeat (5) step();
        sys_rst_n = 1'b0;
        #1;
        check("midrst_filter", key_filter, 4'hF);
        check("midrst_press", key_press, 4'h0);
        repeat (2) step();
        base = edge_no;
        sys_rst_n = 1'b1;
        repeat (14) step();
        check_int("midrst_press_edge", press_edge[3] - base, D + 2);
        check_int("midrst_press_count", press_cnt[3] + press_cnt[0] + press_cnt[1] + press_cnt[2], 1);
        key = 4'hF;
        repeat (14) step();

        // Random activity: busy bouncing, then slow presses long enough for long events.
        repeat (1500) begin
            for (int ch = 0; ch < KN; ch++)
                if ($urandom_range(0, 5) == 0) key[ch] = ~key[ch];
            step();
        end
        repeat (1500) begin
            for (int ch = 0; ch < KN; ch++)
                if ($urandom_range(0, 39) == 0) key[ch] = ~key[ch];
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
